legv8_sc_core: RTL and testbench

- Single-cycle LEGv8 subset processor core with an internal 32x64 register file and a doubleword data memory.
- Instruction memory is external and combinational: the core drives PC and receives INSTRUCTION in the same cycle.
- Every instruction completes in one CLOCK cycle.
- Internal datapath and control signals are exported as debug outputs for bench observation.

---
 rtl/legv8_sc_core.sv | 215 +++++++++++++++++++++
 tb/tb_legv8_sc_core.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_sc_core.sv
// ---------------------------------------------------------------------------
// legv8_sc_core
//   Single-cycle LEGv8 subset core: LDUR, STUR, ADD, SUB, AND, ORR, ADDI,
//   CBZ and B. Every instruction retires in one clock. The register file
//   (32 x 64, X31 = XZR) and a doubleword data memory live inside the core;
//   instruction memory is external and combinational.
//
// Ports
//   CLOCK, RESET_N        clock (rising edge) and async active-low reset
//   PC                    current instruction byte address to imem
//   INSTRUCTION           instruction word at PC, combinational from imem
//   CONTROL_*             decoded control lines for the current instruction
//   READ_REG_1/2          register file read indices (Rn, Rm-or-Rt)
//   WRITE_REG             destination index (Rd/Rt)
//   REG_DATA1/2           register file read data
//   ALU_Result_Out        ALU result, also the data memory byte address
//   data_memory_out       data memory read data (0 unless MEMREAD)
//   WRITE_REG_DATA        write-back value
//
// DMEM_WORDS is expected to be a power of two, at least 2.
// ---------------------------------------------------------------------------
module legv8_sc_core #(
  parameter int          DMEM_WORDS = 32,
  parameter logic [63:0] PC_RESET   = 64'h0
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  output logic [63:0] PC,
  input  logic [31:0] INSTRUCTION,
  output logic        CONTROL_REG2LOC,
  output logic        CONTROL_REGWRITE,
  output logic        CONTROL_MEMREAD,
  output logic        CONTROL_MEMWRITE,
  output logic        CONTROL_BRANCH,
  output logic [4:0]  READ_REG_1,
  output logic [4:0]  READ_REG_2,
  output logic [4:0]  WRITE_REG,
  output logic [63:0] REG_DATA1,
  output logic [63:0] REG_DATA2,
  output logic [63:0] ALU_Result_Out,
  output logic [63:0] data_memory_out,
  output logic [63:0] WRITE_REG_DATA
);

  localparam int IDX_W = $clog2(DMEM_WORDS);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_ORR,
    ALU_PASSB,
    ALU_ZERO
  } alu_op_t;

  logic [63:0] regs [0:31];
  logic [63:0] dmem [0:DMEM_WORDS-1];

  logic [10:0]      opcode;
  alu_op_t          alu_op;
  logic             use_imm;
  logic             uncond_branch;
  logic [63:0]      imm_val;
  logic [63:0]      alu_b;
  logic             alu_zero;
  logic             branch_taken;
  logic [63:0]      branch_offset;
  logic [63:0]      pc_next;
  logic [63:0]      dword_index;
  logic             dmem_in_range;
  logic [IDX_W-1:0] dmem_idx;

  assign opcode = INSTRUCTION[31:21];

  // Instruction decode. Anything not recognised falls through as a NOP with
  // every control low and the ALU forced to zero. B is unconditional, so it
  // does not raise CONTROL_BRANCH (that line marks CBZ only).
  always_comb begin
    CONTROL_REG2LOC  = 1'b0;
    CONTROL_REGWRITE = 1'b0;
    CONTROL_MEMREAD  = 1'b0;
    CONTROL_MEMWRITE = 1'b0;
    CONTROL_BRANCH   = 1'b0;
    uncond_branch    = 1'b0;
    use_imm          = 1'b0;
    imm_val          = 64'h0;
    alu_op           = ALU_ZERO;
    casez (opcode)
      11'b11111000010: begin // LDUR
        CONTROL_REGWRITE = 1'b1;
        CONTROL_MEMREAD  = 1'b1;
        use_imm          = 1'b1;
        imm_val          = {{55{INSTRUCTION[20]}}, INSTRUCTION[20:12]};
        alu_op           = ALU_ADD;
      end
      11'b11111000000: begin // STUR
        CONTROL_REG2LOC  = 1'b1;
        CONTROL_MEMWRITE = 1'b1;
        use_imm          = 1'b1;
        imm_val          = {{55{INSTRUCTION[20]}}, INSTRUCTION[20:12]};
        alu_op           = ALU_ADD;
      end
      11'b10001011000: begin // ADD
        CONTROL_REGWRITE = 1'b1;
        alu_op           = ALU_ADD;
      end
      11'b11001011000: begin // SUB
        CONTROL_REGWRITE = 1'b1;
        alu_op           = ALU_SUB;
      end
      11'b10001010000: begin // AND
        CONTROL_REGWRITE = 1'b1;
        alu_op           = ALU_AND;
      end
      11'b10101010000: begin // ORR
        CONTROL_REGWRITE = 1'b1;
        alu_op           = ALU_ORR;
      end
      11'b1001000100?: begin // ADDI
        CONTROL_REGWRITE = 1'b1;
        use_imm          = 1'b1;
        imm_val          = {52'h0, INSTRUCTION[21:10]};
        alu_op           = ALU_ADD;
      end
      11'b10110100???: begin // CBZ
        CONTROL_REG2LOC  = 1'b1;
        CONTROL_BRANCH   = 1'b1;
        alu_op           = ALU_PASSB;
      end
      11'b000101?????: begin // B
        uncond_branch    = 1'b1;
        alu_op           = ALU_ADD;
      end
      default: begin
      end
    endcase
  end

  assign READ_REG_1 = INSTRUCTION[9:5];
  assign READ_REG_2 = CONTROL_REG2LOC ? INSTRUCTION[4:0] : INSTRUCTION[20:16];
  assign WRITE_REG  = INSTRUCTION[4:0];

  // XZR is decoded on the read side so it reads zero regardless of storage.
  assign REG_DATA1 = (READ_REG_1 == 5'd31) ? 64'h0 : regs[READ_REG_1];
  assign REG_DATA2 = (READ_REG_2 == 5'd31) ? 64'h0 : regs[READ_REG_2];

  assign alu_b = use_imm ? imm_val : REG_DATA2;

  // ALU. CBZ passes the tested register straight through so the zero flag
  // directly answers "is X[Rt] zero".
  always_comb begin
    ALU_Result_Out = 64'h0;
    case (alu_op)
      ALU_ADD:   ALU_Result_Out = REG_DATA1 + alu_b;
      ALU_SUB:   ALU_Result_Out = REG_DATA1 - alu_b;
      ALU_AND:   ALU_Result_Out = REG_DATA1 & alu_b;
      ALU_ORR:   ALU_Result_Out = REG_DATA1 | alu_b;
      ALU_PASSB: ALU_Result_Out = alu_b;
      default:   ALU_Result_Out = 64'h0;
    endcase
  end

  assign alu_zero = (ALU_Result_Out == 64'h0);

  // The memory is doubleword granular: the low three address bits are
  // dropped, and anything past the end of the array reads as zero and
  // ignores writes instead of aliasing onto a low entry.
  assign dword_index   = ALU_Result_Out >> 3;
  assign dmem_in_range = (dword_index < 64'(DMEM_WORDS));
  assign dmem_idx      = dword_index[IDX_W-1:0];

  assign data_memory_out = (CONTROL_MEMREAD && dmem_in_range) ? dmem[dmem_idx] : 64'h0;
  assign WRITE_REG_DATA  = CONTROL_MEMREAD ? data_memory_out : ALU_Result_Out;

  // Next-PC selection. The offset field depends on the branch kind; both
  // are word offsets, and the add wraps modulo 2^64.
  assign branch_offset = uncond_branch
                         ? ({{38{INSTRUCTION[25]}}, INSTRUCTION[25:0]} << 2)
                         : ({{45{INSTRUCTION[23]}}, INSTRUCTION[23:5]} << 2);
  assign branch_taken  = uncond_branch | (CONTROL_BRANCH & alu_zero);
  assign pc_next       = branch_taken ? (PC + branch_offset) : (PC + 64'd4);

  // Program counter register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      PC <= PC_RESET;
    end else begin
      PC <= pc_next;
    end
  end

  // Register file write port. Writes aimed at X31 are discarded; reads in
  // the same cycle see the old value because write-back is edge-triggered.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 64'h0;
      end
    end else if (CONTROL_REGWRITE && (WRITE_REG != 5'd31)) begin
      regs[WRITE_REG] <= WRITE_REG_DATA;
    end
  end

  // Data memory write port, STUR only, dropped when out of range.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        dmem[i] <= 64'h0;
      end
    end else if (CONTROL_MEMWRITE && dmem_in_range) begin
      dmem[dmem_idx] <= REG_DATA2;
    end
  end

endmodule

// File: tb/tb_legv8_sc_core.sv
// ---------------------------------------------------------------------------
// tb_legv8_sc_core
//   Directed bench for legv8_sc_core. The bench plays the part of the
//   instruction memory: it drives INSTRUCTION for whatever PC the core is
//   at, checks the combinational decode/datapath outputs mid-cycle, then
//   clocks and checks the resulting PC and architectural state.
// ---------------------------------------------------------------------------
module tb_legv8_sc_core;

  logic        CLOCK;
  logic        RESET_N;
  logic [63:0] PC;
  logic [31:0] INSTRUCTION;
  logic        CONTROL_REG2LOC;
  logic        CONTROL_REGWRITE;
  logic        CONTROL_MEMREAD;
  logic        CONTROL_MEMWRITE;
  logic        CONTROL_BRANCH;
  logic [4:0]  READ_REG_1;
  logic [4:0]  READ_REG_2;
  logic [4:0]  WRITE_REG;
  logic [63:0] REG_DATA1;
  logic [63:0] REG_DATA2;
  logic [63:0] ALU_Result_Out;
  logic [63:0] data_memory_out;
  logic [63:0] WRITE_REG_DATA;

  int          passCount;
  int          checkCount;
  logic [63:0] expPc;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  legv8_sc_core #(
    .DMEM_WORDS(32),
    .PC_RESET  (64'h0)
  ) dut (
    .CLOCK           (CLOCK),
    .RESET_N         (RESET_N),
    .PC              (PC),
    .INSTRUCTION     (INSTRUCTION),
    .CONTROL_REG2LOC (CONTROL_REG2LOC),
    .CONTROL_REGWRITE(CONTROL_REGWRITE),
    .CONTROL_MEMREAD (CONTROL_MEMREAD),
    .CONTROL_MEMWRITE(CONTROL_MEMWRITE),
    .CONTROL_BRANCH  (CONTROL_BRANCH),
    .READ_REG_1      (READ_REG_1),
    .READ_REG_2      (READ_REG_2),
    .WRITE_REG       (WRITE_REG),
    .REG_DATA1       (REG_DATA1),
    .REG_DATA2       (REG_DATA2),
    .ALU_Result_Out  (ALU_Result_Out),
    .data_memory_out (data_memory_out),
    .WRITE_REG_DATA  (WRITE_REG_DATA)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Instruction encoders for the supported formats.
  function automatic logic [31:0] encR(input logic [10:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rn, input logic [4:0] rm);
    return {opc, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] encI(input logic [4:0] rd, input logic [4:0] rn,
                                       input logic [11:0] imm);
    return {10'b1001000100, imm, rn, rd};
  endfunction

  function automatic logic [31:0] encD(input logic [10:0] opc, input logic [4:0] rt,
                                       input logic [4:0] rn, input logic [8:0] off);
    return {opc, off, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] encCbz(input logic [4:0] rt, input logic [18:0] imm);
    return {8'b10110100, imm, rt};
  endfunction

  function automatic logic [31:0] encB(input logic [25:0] imm);
    return {6'b000101, imm};
  endfunction

  // Present an instruction and let the combinational paths settle.
  task automatic applyStimulus(input logic [31:0] instr);
    INSTRUCTION = instr;
    #1;
  endtask

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
  endtask

  // Clock one instruction through and check where the PC landed.
  task automatic advance(input string tag, input logic [63:0] nextPc);
    @(posedge CLOCK);
    #1;
    expPc = nextPc;
    checkOutput(tag, PC, expPc);
  endtask

  initial begin
    passCount   = 0;
    checkCount  = 0;
    expPc       = 64'h0;
    RESET_N     = 1'b1;
    INSTRUCTION = 32'h0;

    // Power-on reset
    #2 RESET_N = 1'b0;
    #1;
    checkOutput("reset_pc", PC, 64'h0);
    @(negedge CLOCK);
    RESET_N = 1'b1;

    // Put something in X1 so the mid-cycle reset has state to clear
    applyStimulus(encI(5'd1, 5'd31, 12'd9));
    advance("pc_first", 64'd4);
    applyStimulus(encR(OP_ADD, 5'd3, 5'd1, 5'd2));
    checkOutput("x1_before_reset", REG_DATA1, 64'd9);

    // Mid-cycle asynchronous reset
    RESET_N = 1'b0;
    #1;
    checkOutput("midreset_pc", PC, 64'h0);
    checkOutput("midreset_x1", REG_DATA1, 64'h0);
    @(posedge CLOCK);
    #1;
    checkOutput("reset_hold_pc", PC, 64'h0);
    RESET_N = 1'b1;
    expPc = 64'h0;

    // ADDI X1,XZR,#5 ; ADDI X2,XZR,#3
    applyStimulus(encI(5'd1, 5'd31, 12'd5));
    checkOutput("addi_regwrite", {63'h0, CONTROL_REGWRITE}, 64'd1);
    checkOutput("addi_wdata", WRITE_REG_DATA, 64'd5);
    advance("pc_addi1", 64'd4);
    applyStimulus(encI(5'd2, 5'd31, 12'd3));
    advance("pc_addi2", 64'd8);

    // R-type ALU ops
    applyStimulus(encR(OP_ADD, 5'd3, 5'd1, 5'd2));
    checkOutput("add_result", ALU_Result_Out, 64'd8);
    checkOutput("add_reg2loc", {63'h0, CONTROL_REG2LOC}, 64'd0);
    advance("pc_add", expPc + 64'd4);
    applyStimulus(encR(OP_SUB, 5'd4, 5'd1, 5'd2));
    checkOutput("sub_result", ALU_Result_Out, 64'd2);
    advance("pc_sub", expPc + 64'd4);
    applyStimulus(encR(OP_AND, 5'd8, 5'd1, 5'd2));
    checkOutput("and_result", ALU_Result_Out, 64'd1);
    advance("pc_and", expPc + 64'd4);
    applyStimulus(encR(OP_ORR, 5'd9, 5'd1, 5'd2));
    checkOutput("orr_result", ALU_Result_Out, 64'd7);
    advance("pc_orr", expPc + 64'd4);
    applyStimulus(encR(OP_SUB, 5'd5, 5'd2, 5'd1));
    checkOutput("sub_negative", ALU_Result_Out, 64'hFFFF_FFFF_FFFF_FFFE);
    advance("pc_sub2", expPc + 64'd4);

    // Read back earlier results
    applyStimulus(encR(OP_ADD, 5'd10, 5'd3, 5'd4));
    checkOutput("readback_x3", REG_DATA1, 64'd8);
    checkOutput("readback_x4", REG_DATA2, 64'd2);
    advance("pc_readback", expPc + 64'd4);
    applyStimulus(encR(OP_ORR, 5'd10, 5'd5, 5'd9));
    checkOutput("readback_x5", REG_DATA1, 64'hFFFF_FFFF_FFFF_FFFE);
    checkOutput("readback_x9", REG_DATA2, 64'd7);
    advance("pc_readback2", expPc + 64'd4);

    // Build X1=16, X2=0xABCD (0xABC shifted left by four, plus 0xD)
    applyStimulus(encI(5'd1, 5'd31, 12'd16));
    advance("pc_x1_16", expPc + 64'd4);
    applyStimulus(encI(5'd2, 5'd31, 12'hABC));
    advance("pc_x2_abc", expPc + 64'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(encR(OP_ADD, 5'd2, 5'd2, 5'd2));
      advance("pc_x2_shift", expPc + 64'd4);
    end
    applyStimulus(encI(5'd2, 5'd2, 12'hD));
    checkOutput("x2_value", WRITE_REG_DATA, 64'hABCD);
    advance("pc_x2_done", expPc + 64'd4);

    // STUR X2,[X1,#8]
    applyStimulus(encD(OP_STUR, 5'd2, 5'd1, 9'd8));
    checkOutput("stur_memwrite", {63'h0, CONTROL_MEMWRITE}, 64'd1);
    checkOutput("stur_regwrite", {63'h0, CONTROL_REGWRITE}, 64'd0);
    checkOutput("stur_reg2", {59'h0, READ_REG_2}, 64'd2);
    checkOutput("stur_addr", ALU_Result_Out, 64'd24);
    checkOutput("stur_dmem_out", data_memory_out, 64'h0);
    advance("pc_stur", expPc + 64'd4);

    // LDUR X6,[X1,#8]
    applyStimulus(encD(OP_LDUR, 5'd6, 5'd1, 9'd8));
    checkOutput("ldur_memread", {63'h0, CONTROL_MEMREAD}, 64'd1);
    checkOutput("ldur_addr", ALU_Result_Out, 64'd24);
    checkOutput("ldur_data", data_memory_out, 64'hABCD);
    checkOutput("ldur_wdata", WRITE_REG_DATA, 64'hABCD);
    advance("pc_ldur", expPc + 64'd4);
    applyStimulus(encR(OP_ADD, 5'd11, 5'd6, 5'd31));
    checkOutput("x6_loaded", REG_DATA1, 64'hABCD);
    advance("pc_x6", expPc + 64'd4);

    // Non-load at the same address must not expose memory data
    applyStimulus(encI(5'd18, 5'd1, 12'd8));
    checkOutput("nonload_dmem_out", data_memory_out, 64'h0);
    checkOutput("nonload_wdata", WRITE_REG_DATA, 64'd24);
    advance("pc_nonload", expPc + 64'd4);

    // Low address bits ignored: address 29 hits the same doubleword
    applyStimulus(encD(OP_LDUR, 5'd12, 5'd1, 9'd13));
    checkOutput("ldur_unaligned", data_memory_out, 64'hABCD);
    advance("pc_unaligned", expPc + 64'd4);

    // Negative offset: X15=32, LDUR X14,[X15,#-8] -> address 24
    applyStimulus(encI(5'd15, 5'd31, 12'd32));
    advance("pc_x15", expPc + 64'd4);
    applyStimulus(encD(OP_LDUR, 5'd14, 5'd15, 9'h1F8));
    checkOutput("ldur_neg_addr", ALU_Result_Out, 64'd24);
    checkOutput("ldur_neg_data", data_memory_out, 64'hABCD);
    advance("pc_negoff", expPc + 64'd4);

    // Out-of-range: read of 256 is 0, store to 256 is dropped
    applyStimulus(encI(5'd11, 5'd31, 12'd256));
    advance("pc_x11", expPc + 64'd4);
    applyStimulus(encD(OP_LDUR, 5'd12, 5'd11, 9'd0));
    checkOutput("oor_addr", ALU_Result_Out, 64'd256);
    checkOutput("oor_read", data_memory_out, 64'h0);
    advance("pc_oor_ld", expPc + 64'd4);
    applyStimulus(encD(OP_STUR, 5'd2, 5'd11, 9'd0));
    advance("pc_oor_st", expPc + 64'd4);
    applyStimulus(encD(OP_LDUR, 5'd13, 5'd31, 9'd0));
    checkOutput("oor_no_alias", data_memory_out, 64'h0);
    advance("pc_entry0", expPc + 64'd4);

    // CBZ taken: X7 is still zero
    applyStimulus(encCbz(5'd7, 19'd3));
    checkOutput("cbz_branch", {63'h0, CONTROL_BRANCH}, 64'd1);
    checkOutput("cbz_reg2loc", {63'h0, CONTROL_REG2LOC}, 64'd1);
    checkOutput("cbz_reg2", {59'h0, READ_REG_2}, 64'd7);
    checkOutput("cbz_regwrite", {63'h0, CONTROL_REGWRITE}, 64'd0);
    checkOutput("cbz_alu_zero", ALU_Result_Out, 64'h0);
    advance("pc_cbz_taken", expPc + 64'd12);

    // CBZ not taken once X7=1
    applyStimulus(encI(5'd7, 5'd31, 12'd1));
    advance("pc_x7", expPc + 64'd4);
    applyStimulus(encCbz(5'd7, 19'd3));
    checkOutput("cbz_alu_pass", ALU_Result_Out, 64'd1);
    advance("pc_cbz_not_taken", expPc + 64'd4);

    // B #-2 goes back two instructions
    applyStimulus(encB(26'h3FF_FFFE));
    checkOutput("b_branch_flag", {63'h0, CONTROL_BRANCH}, 64'd0);
    checkOutput("b_regwrite", {63'h0, CONTROL_REGWRITE}, 64'd0);
    advance("pc_b_back", expPc - 64'd8);

    // Writes to XZR are discarded
    applyStimulus(encR(OP_ADD, 5'd31, 5'd1, 5'd2));
    checkOutput("xzr_regwrite", {63'h0, CONTROL_REGWRITE}, 64'd1);
    checkOutput("xzr_wdata", WRITE_REG_DATA, 64'hABDD);
    advance("pc_xzr_wr", expPc + 64'd4);
    applyStimulus(encR(OP_ADD, 5'd16, 5'd31, 5'd1));
    checkOutput("xzr_reads_zero", REG_DATA1, 64'h0);
    checkOutput("xzr_sum", ALU_Result_Out, 64'd16);
    advance("pc_xzr_rd", expPc + 64'd4);

    // Undefined opcode: all controls low, ALU 0, only PC moves
    applyStimulus(32'h0000_0001);
    checkOutput("nop_controls",
                {59'h0, CONTROL_REG2LOC, CONTROL_REGWRITE, CONTROL_MEMREAD,
                 CONTROL_MEMWRITE, CONTROL_BRANCH}, 64'h0);
    checkOutput("nop_alu", ALU_Result_Out, 64'h0);
    checkOutput("nop_wdata", WRITE_REG_DATA, 64'h0);
    advance("pc_nop", expPc + 64'd4);
    applyStimulus(encR(OP_ADD, 5'd17, 5'd1, 5'd31));
    checkOutput("nop_x1_kept", REG_DATA1, 64'd16);
    advance("pc_final", expPc + 64'd4);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
